// File: rtl/common_types_pkg.sv
// Shared encodings and types for the AHB timer slave: AHB transfer and
// response codes, register offsets, the CTRL bit-field layout and the
// bus-side FSM states.
package common_types_pkg;

  // AHB transfer types (htrans)
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB slave responses (hresp)
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Only 32-bit accesses are legal
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Register offsets, indexed by haddr[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_CMP      = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  // CTRL register: bit2 AUTORELOAD, bit1 IE, bit0 EN
  typedef struct packed {
    logic autoreload;
    logic ie;
    logic en;
  } ctrl_t;

  // Data-phase state of the bus interface
  typedef enum logic [1:0] {
    ST_IDLE,    // no data phase in progress
    ST_ACCESS,  // zero-wait OKAY data phase
    ST_ERR1,    // first ERROR cycle (hready low)
    ST_ERR2     // second ERROR cycle (hready high)
  } bus_state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_bus_if.sv
// AHB bus bundle between the address multiplexor (master side) and a slave.
interface ahb_bus_if;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  modport master (
    output haddr, hburst, hsize, htrans, hwdata, hwrite,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hburst, hsize, htrans, hwdata, hwrite,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/timer_core.sv
// Prescaler, 32-bit COUNT register and compare logic. A bus write to COUNT
// takes priority over the tick update; the compare result is reported as a
// one-cycle match_set pulse for the STATUS register in the parent.
module timer_core #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_i,
  input  logic                  autoreload_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [31:0]           cmp_i,
  input  logic                  count_wr_i,
  input  logic [31:0]           count_wdata_i,
  output logic [31:0]           count_o,
  output logic                  tick_o,
  output logic                  match_set_o
);
  import common_types_pkg::*;

  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [31:0]           count_q, count_d;
  logic                  tick;
  logic                  hit;

  // >= rather than == so that lowering PRESCALE below the running prescaler
  // value wraps immediately instead of running on to 2^PRESCALE_W.
  assign tick = en_i && (psc_q >= prescale_i);
  assign hit  = (count_q == cmp_i);

  // Next-state for prescaler and COUNT; disabled timer parks the prescaler at 0
  always_comb begin
    psc_d   = psc_q;
    count_d = count_q;
    if (!en_i) begin
      psc_d = '0;
    end else if (tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PRESCALE_W'(1);
    end
    if (count_wr_i) begin
      count_d = count_wdata_i;
    end else if (tick) begin
      if (hit && autoreload_i) begin
        count_d = '0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // Prescaler and COUNT state registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      psc_q   <= '0;
      count_q <= '0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign tick_o      = tick;
  assign match_set_o = tick && hit;

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB slave exposing a prescaled 32-bit timer with compare-match interrupt.
// Zero-wait-state OKAY accesses to offsets 0-4; unmapped offsets and
// non-word sizes get the two-cycle ERROR response and change nothing.
module ahb_timer_slave #(
  parameter int PRESCALE_W = 16
) (
  input  logic     clk,
  input  logic     nrst,
  ahb_bus_if.slave abif,
  output logic     tmri
);
  import common_types_pkg::*;

  bus_state_e            state_q, state_d;
  logic [2:0]            dp_addr_q, dp_addr_d;
  logic                  dp_write_q, dp_write_d;

  ctrl_t                 ctrl_q, ctrl_d;
  logic                  match_q, match_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           cmp_q, cmp_d;

  logic                  hready;
  logic                  addr_accept;
  logic                  addr_err;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  count_wr;
  logic [31:0]           count;
  logic                  tick;
  logic                  match_set;
  logic [31:0]           rdata;
  logic                  unused_bus_bits;

  // Address bits outside the word offset and the burst type do not matter here
  assign unused_bus_bits = ^{abif.hburst, abif.haddr[31:5], abif.haddr[1:0], tick};

  assign hready      = (state_q != ST_ERR1);
  assign addr_accept = trans_active(abif.htrans) && hready;
  assign addr_err    = (abif.haddr[4:2] > REG_PRESCALE) || (abif.hsize != HSIZE_WORD);
  assign wr_fire     = (state_q == ST_ACCESS) && dp_write_q;
  assign rd_fire     = (state_q == ST_ACCESS) && !dp_write_q;
  assign count_wr    = wr_fire && (dp_addr_q == REG_COUNT);

  // Bus FSM next state: capture the address phase, walk the ERROR sequence
  always_comb begin
    state_d    = ST_IDLE;
    dp_addr_d  = dp_addr_q;
    dp_write_d = dp_write_q;
    if (addr_accept) begin
      dp_addr_d  = abif.haddr[4:2];
      dp_write_d = abif.hwrite;
      state_d    = addr_err ? ST_ERR1 : ST_ACCESS;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end
  end

  // Bus FSM state and registered address phase
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      dp_addr_q  <= '0;
      dp_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dp_addr_q  <= dp_addr_d;
      dp_write_q <= dp_write_d;
    end
  end

  // Register-file next state; a hardware match beats a same-cycle W1C
  always_comb begin
    ctrl_d     = ctrl_q;
    match_d    = match_q;
    prescale_d = prescale_q;
    cmp_d      = cmp_q;
    if (wr_fire) begin
      case (dp_addr_q)
        REG_CTRL:     ctrl_d = ctrl_t'(abif.hwdata[2:0]);
        REG_STATUS:   if (abif.hwdata[0]) match_d = 1'b0;
        REG_CMP:      cmp_d = abif.hwdata;
        REG_PRESCALE: prescale_d = abif.hwdata[PRESCALE_W-1:0];
        default:      ;
      endcase
    end
    if (match_set) begin
      match_d = 1'b1;
    end
  end

  // Register-file state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      prescale_q <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
    end else begin
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
      cmp_q      <= cmp_d;
    end
  end

  // Read mux: current register values, zero outside a read data phase
  always_comb begin
    rdata = '0;
    if (rd_fire) begin
      case (dp_addr_q)
        REG_CTRL:     rdata = {29'd0, ctrl_q};
        REG_STATUS:   rdata = {31'd0, match_q};
        REG_COUNT:    rdata = count;
        REG_CMP:      rdata = cmp_q;
        REG_PRESCALE: rdata = 32'(prescale_q);
        default:      rdata = '0;
      endcase
    end
  end

  timer_core #(
    .PRESCALE_W(PRESCALE_W)
  ) u_core (
    .clk          (clk),
    .nrst         (nrst),
    .en_i         (ctrl_q.en),
    .autoreload_i (ctrl_q.autoreload),
    .prescale_i   (prescale_q),
    .cmp_i        (cmp_q),
    .count_wr_i   (count_wr),
    .count_wdata_i(abif.hwdata),
    .count_o      (count),
    .tick_o       (tick),
    .match_set_o  (match_set)
  );

  assign abif.hrdata = rdata;
  assign abif.hready = hready;
  assign abif.hresp  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign tmri        = match_q & ctrl_q.ie;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Directed bench for ahb_timer_slave: reset values, register access,
// ERROR responses, prescaled match with auto-reload, free-run wrap,
// write/tick and W1C/match collisions, and reset during an ERROR response.
module tb_ahb_timer_slave;
  import common_types_pkg::*;

  localparam logic [31:0] A_CTRL     = 32'h00;
  localparam logic [31:0] A_STATUS   = 32'h04;
  localparam logic [31:0] A_COUNT    = 32'h08;
  localparam logic [31:0] A_CMP      = 32'h0C;
  localparam logic [31:0] A_PRESCALE = 32'h10;

  logic clk = 1'b0;
  logic nrst;
  logic tmri;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   cyc_en;
  int   t1;
  int   t2;

  logic [31:0] r_data;
  logic        r_rdy;
  logic [1:0]  r_resp1;
  logic [1:0]  r_resp2;
  int          r_waits;
  logic [31:0] exp_w [3];

  ahb_bus_if abif ();

  ahb_timer_slave #(.PRESCALE_W(16)) dut (
    .clk (clk),
    .nrst(nrst),
    .abif(abif),
    .tmri(tmri)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One non-pipelined transfer; starts just after a rising edge, returns just
  // after the edge that ends its last data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    abif.haddr  = addr;
    abif.hwrite = wr;
    abif.hsize  = size;
    abif.htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    abif.htrans = HTRANS_IDLE;
    abif.hwdata = wdata;
    @(negedge clk);
    r_data  = abif.hrdata;
    r_rdy   = abif.hready;
    r_resp1 = abif.hresp;
    r_resp2 = abif.hresp;
    r_waits = 0;
    while (abif.hready !== 1'b1 && r_waits < 8) begin
      @(negedge clk);
      r_waits++;
      r_resp2 = abif.hresp;
    end
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input string tag, input logic [31:0] addr, input logic [31:0] data);
    xfer(1'b1, addr, HSIZE_WORD, data);
    check({tag, " wr resp"}, {29'd0, r_rdy, r_resp1}, {29'd0, 1'b1, HRESP_OKAY});
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    xfer(1'b0, addr, HSIZE_WORD, 32'h0);
    check({tag, " rd resp"}, {29'd0, r_rdy, r_resp1}, {29'd0, 1'b1, HRESP_OKAY});
    check({tag, " rd data"}, r_data, exp);
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits (bounded) for tmri to be seen high at a falling edge
  task automatic wait_tmri(output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < 40) begin
      @(negedge clk);
      if (tmri === 1'b1) begin
        at = cyc;
        n  = 40;
      end else begin
        n++;
      end
    end
  endtask

  task automatic do_reset();
    nrst        = 1'b0;
    abif.htrans = HTRANS_IDLE;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst        = 1'b0;
    abif.haddr  = '0;
    abif.hburst = '0;
    abif.hsize  = HSIZE_WORD;
    abif.htrans = HTRANS_IDLE;
    abif.hwdata = '0;
    abif.hwrite = 1'b0;

    // Outputs held in reset
    repeat (2) @(negedge clk);
    check("reset hready/hresp", {29'd0, abif.hready, abif.hresp}, {29'd0, 1'b1, HRESP_OKAY});
    check("reset hrdata", abif.hrdata, 32'h0);
    check("reset tmri", {31'd0, tmri}, 32'd0);
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1;

    // Reset values
    rd_reg("cmp reset", A_CMP, 32'hFFFF_FFFF);
    rd_reg("count reset", A_COUNT, 32'h0);
    rd_reg("ctrl reset", A_CTRL, 32'h0);
    rd_reg("status reset", A_STATUS, 32'h0);
    rd_reg("prescale reset", A_PRESCALE, 32'h0);

    // Field widths: reserved CTRL bits and PRESCALE zero-extension
    wr_reg("ctrl rsvd", A_CTRL, 32'hFFFF_FFFE);
    check("hrdata in write phase", r_data, 32'h0);
    rd_reg("ctrl rsvd", A_CTRL, 32'h0000_0006);
    wr_reg("prescale wide", A_PRESCALE, 32'hFFFF_FFFF);
    rd_reg("prescale wide", A_PRESCALE, 32'h0000_FFFF);

    // BUSY transfer carries no write
    wr_reg("count seed", A_COUNT, 32'h0000_1234);
    abif.haddr  = A_COUNT;
    abif.hwrite = 1'b1;
    abif.hsize  = HSIZE_WORD;
    abif.htrans = HTRANS_BUSY;
    @(negedge clk);
    check("busy resp", {29'd0, abif.hready, abif.hresp}, {29'd0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    abif.htrans = HTRANS_IDLE;
    abif.hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("after busy resp", {29'd0, abif.hready, abif.hresp}, {29'd0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    rd_reg("count after busy", A_COUNT, 32'h0000_1234);

    // ERROR responses
    do_reset();
    xfer(1'b0, 32'h14, HSIZE_WORD, 32'h0);
    check("err rd cycle1", {29'd0, r_rdy, r_resp1}, {29'd0, 1'b0, HRESP_ERROR});
    check("err rd cycle2 resp", {30'd0, r_resp2}, {30'd0, HRESP_ERROR});
    check("err rd length", r_waits, 32'd1);
    check("err rd hrdata", r_data, 32'h0);
    xfer(1'b1, A_CMP, 3'b001, 32'h0000_1234);
    check("err half cycle1", {29'd0, r_rdy, r_resp1}, {29'd0, 1'b0, HRESP_ERROR});
    check("err half cycle2 resp", {30'd0, r_resp2}, {30'd0, HRESP_ERROR});
    check("err half length", r_waits, 32'd1);
    rd_reg("cmp after err", A_CMP, 32'hFFFF_FFFF);

    // Auto-reload match: tick every 3 cycles, match on the 4th tick
    do_reset();
    wr_reg("psc 2", A_PRESCALE, 32'd2);
    wr_reg("cmp 3", A_CMP, 32'd3);
    wr_reg("ctrl 7", A_CTRL, 32'h7);
    cyc_en = cyc;
    wait_tmri(t1);
    check("match latency", t1 - cyc_en, 32'd12);
    goto_cycle(cyc_en + 13);
    rd_reg("count after reload", A_COUNT, 32'h0);
    wr_reg("w1c", A_STATUS, 32'h1);
    @(negedge clk);
    check("tmri after w1c", {31'd0, tmri}, 32'd0);
    wait_tmri(t2);
    check("match period", t2 - t1, 32'd12);
    goto_cycle(cyc_en + 25);
    wr_reg("w1c 2", A_STATUS, 32'h1);
    @(negedge clk);
    check("tmri after w1c 2", {31'd0, tmri}, 32'd0);
    // W1C committing on the edge where the third match sets
    goto_cycle(cyc_en + 34);
    wr_reg("w1c vs match", A_STATUS, 32'h1);
    @(negedge clk);
    check("match beats w1c", {31'd0, tmri}, 32'd1);
    // COUNT write committing on a tick edge
    goto_cycle(cyc_en + 37);
    wr_reg("count vs tick", A_COUNT, 32'h10);
    rd_reg("count vs tick", A_COUNT, 32'h10);

    // Free-run wrap with a tick every cycle, read back-to-back
    do_reset();
    wr_reg("count fffffffe", A_COUNT, 32'hFFFF_FFFE);
    wr_reg("psc 0", A_PRESCALE, 32'd0);
    wr_reg("ctrl 1", A_CTRL, 32'h1);
    exp_w[0] = 32'hFFFF_FFFF;
    exp_w[1] = 32'h0000_0000;
    exp_w[2] = 32'h0000_0001;
    abif.haddr  = A_COUNT;
    abif.hwrite = 1'b0;
    abif.hsize  = HSIZE_WORD;
    abif.htrans = HTRANS_NONSEQ;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      abif.htrans = (i == 2) ? HTRANS_IDLE : HTRANS_SEQ;
      @(negedge clk);
      check($sformatf("wrap read %0d", i), abif.hrdata, exp_w[i]);
    end
    @(posedge clk); #1;

    // Reset during the first ERROR cycle
    do_reset();
    wr_reg("pre ctrl", A_CTRL, 32'h6);
    wr_reg("pre psc", A_PRESCALE, 32'd5);
    wr_reg("pre count", A_COUNT, 32'h55);
    wr_reg("pre cmp", A_CMP, 32'h77);
    abif.haddr  = 32'h18;
    abif.hwrite = 1'b0;
    abif.hsize  = HSIZE_WORD;
    abif.htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    abif.htrans = HTRANS_IDLE;
    @(negedge clk);
    check("err before reset", {29'd0, abif.hready, abif.hresp}, {29'd0, 1'b0, HRESP_ERROR});
    nrst = 1'b0;
    #1;
    check("ready in reset", {29'd0, abif.hready, abif.hresp}, {29'd0, 1'b1, HRESP_OKAY});
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("idle after reset", {29'd0, abif.hready, abif.hresp}, {29'd0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    rd_reg("ctrl post", A_CTRL, 32'h0);
    rd_reg("psc post", A_PRESCALE, 32'h0);
    rd_reg("count post", A_COUNT, 32'h0);
    rd_reg("cmp post", A_CMP, 32'hFFFF_FFFF);
    rd_reg("status post", A_STATUS, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_timer_slave.md
AHB_TIMER_SLAVE -- requirements
Module: ahb_timer_slave

Interface
REQ-001 Parameter PRESCALE_W, default 16, width of the prescaler register and counter.
REQ-002 clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 abif  ahb_bus_if (slave side)  -  inputs haddr, hburst, hsize, htrans, hwdata, hwrite; outputs hrdata, hready, hresp.
REQ-005 tmri  output  1  timer interrupt request, level-high, to interrupt_in_sync.
REQ-006 One clock; reset is asynchronous and active-low (clk, nrst).

Function
REQ-007 ahb_multiplexor decodes the address; any NONSEQ/SEQ transfer on abif targets this slave, and deselected cycles present IDLE.
REQ-008 Address phase is accepted when htrans is NONSEQ or SEQ and hready=1; haddr[4:2], hwrite and hsize are registered for the data phase.
REQ-009 Register map (haddr[4:2]):
  - 0 CTRL: bit0 EN, bit1 IE, bit2 AUTORELOAD; other bits read 0.
  - 1 STATUS: bit0 MATCH, write-1-to-clear.
  - 2 COUNT: 32-bit, read/write.
  - 3 CMP: 32-bit, read/write.
  - 4 PRESCALE: PRESCALE_W bits, zero-extended on read.
REQ-010 A valid access completes with zero wait states: hready=1 and hresp=OKAY in its data phase.
REQ-011 Reads return the register value on hrdata during the data phase, sampled before any same-cycle update.
REQ-012 Writes take hwdata in the data phase and commit at the end of that cycle.
REQ-013 Offsets 5-7, or hsize not word, get a two-cycle ERROR response:
  - cycle 1: hready=0, hresp=ERROR.
  - cycle 2: hready=1, hresp=ERROR.
  - No register changes.
REQ-014 IDLE/BUSY transfers get hready=1, hresp=OKAY, with no side effect.
REQ-015 Prescaler, while EN=1:
  - Counts 0..PRESCALE.
  - On the cycle it equals PRESCALE it wraps to 0 and asserts tick.
  - PRESCALE=0 gives a tick every cycle.
REQ-016 On tick:
  - If COUNT==CMP: MATCH is set, and COUNT goes to 0 when AUTORELOAD=1, else to COUNT+1.
  - Otherwise COUNT increments modulo 2^32, so 0xFFFFFFFF wraps to 0.
REQ-017 EN=0 freezes the prescaler and COUNT. Clearing EN resets the prescaler to 0.
REQ-018 A bus write to COUNT or PRESCALE in the same cycle as a tick wins over the tick update.
REQ-019 A hardware MATCH set wins over a same-cycle write-1-to-clear.
REQ-020 tmri = MATCH & IE, driven combinationally from registered state.
REQ-021 hrdata is 0 in every cycle other than a valid read data phase.

Reset
REQ-022 While nrst=0, all of the following are held at 0 and the pipeline returns to idle: CTRL, STATUS, COUNT, PRESCALE, prescaler counter, registered address phase, tmri, hrdata, hresp (OKAY).
REQ-023 hready=1 while nrst=0.
REQ-024 A reset asserted mid-ERROR response abandons the response; the first cycle after reset is idle.
REQ-025 CMP resets to 0xFFFFFFFF.

Structure
REQ-026 Register offset constants and the CTRL bit-field struct live in common_types_pkg; the htrans/hresp encodings come from the same package.
REQ-027 The prescaler, COUNT and compare logic form one sub-module, timer_core, exposing tick, match_set and write-override ports; the AHB decode and register file stay in ahb_timer_slave.

Verification
REQ-028 Read after reset: read CMP, then COUNT -> 0xFFFFFFFF, then 0x00000000, each with hready=1, hresp=OKAY.
REQ-029 Auto-reload match: PRESCALE=2, CMP=3, CTRL=0x7 -> MATCH sets and tmri rises 12 cycles after EN, COUNT reads 0, the period repeats every 12 cycles, and a W1C to STATUS drops tmri next cycle.
REQ-030 Free-run wrap: write COUNT=0xFFFFFFFE, PRESCALE=0, CTRL=0x1 -> COUNT reads 0xFFFFFFFF, then 0x00000000, then 0x00000001 on consecutive ticks.
REQ-031 Error response: read offset 0x14 -> (hready=0, hresp=ERROR) then (hready=1, hresp=ERROR). A halfword write to 0x0C -> same response, and CMP is unchanged.
REQ-032 Collision: a COUNT write of 0x10 coincident with a tick -> COUNT=0x10. A STATUS W1C coincident with a match -> MATCH stays 1.
REQ-033 Reset mid-operation: nrst=0 during the first ERROR cycle -> after release all registers hold their reset values and the next read completes OKAY.
